// File: rtl/sequence_control_p.sv
`default_nettype none
// ============================================================================
// Module   : sequence_control_p
// Purpose  : A09 multi-cycle control sequencer with memory ready handshake,
//            bounded wait-state fault and optional interrupt (SEQ_INTERRUPT_EN)
// Revision : 1.0  initial release
// ============================================================================
module sequence_control_p #(
  parameter int DataWidth = 16,
  parameter int WaitMax   = 7
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [DataWidth-1:0] IR,
  input  logic [3:0]           ALU_FlgsIn,
  input  logic                 MEM_Rdy,
`ifdef SEQ_INTERRUPT_EN
  input  logic                 Int_Req,
  output logic                 Int_Ack,
`endif
  output logic                 STK_Ld,
  output logic                 IR_Ld,
  output logic                 PC_Ld,
  output logic                 PC_Rst,
  output logic                 PC_Inc,
  output logic                 MEM_Wr,
  output logic                 MEM_En,
  output logic                 REG_WE,
  output logic                 FLG_Ld,
  output logic                 FLG_Rst,
  output logic                 BRA_Src,
  output logic                 Src1_Sel,
  output logic [1:0]           PC_Src,
  output logic [1:0]           ADDR_Src,
  output logic [1:0]           DATA_Src,
  output logic [2:0]           REG_Dest,
  output logic [2:0]           REG_Src1,
  output logic [2:0]           REG_Src2,
  output logic [3:0]           ALU_Op,
  output logic                 Halt,
  output logic                 Fault
);

  localparam int         c_OFS      = DataWidth - 16;
  localparam logic [7:0] c_WAIT_MAX = 8'(WaitMax);
  localparam logic [3:0] c_OP_LDI = 4'd1, c_OP_LD  = 4'd2, c_OP_ST  = 4'd3,
                         c_OP_STX = 4'd4, c_OP_JPL = 4'd5, c_OP_RET = 4'd6,
                         c_OP_BRD = 4'd7, c_OP_BRX = 4'd8, c_OP_ALU = 4'd9,
                         c_OP_HLT = 4'd15;

  typedef enum logic [2:0] {
    S_RESET      = 3'd0,
    S_FETCH_ADDR = 3'd1,
    S_FETCH_WAIT = 3'd2,
    S_DECODE     = 3'd3,
    S_EXECUTE    = 3'd4,
    S_HALT       = 3'd5,
    S_FAULT      = 3'd6
`ifdef SEQ_INTERRUPT_EN
    , S_INT      = 3'd7
`endif
  } state_t;

  state_t     r_state, w_next;
  logic [7:0] r_wait;
  logic       w_wait_clr, w_wait_inc, w_wait_hit, w_taken;
  logic [3:0] w_opcode, w_alu_fn;
  logic [1:0] w_cond;
  logic       w_unused;

  assign w_opcode   = IR[DataWidth-1 -: 4];
  assign w_cond     = IR[11+c_OFS -: 2];
  assign w_alu_fn   = IR[3+c_OFS -: 4];
  assign w_unused   = ^IR[8+c_OFS -: 2];
  assign w_wait_hit = (r_wait + 8'd1) == c_WAIT_MAX;

  assign REG_Dest = IR[11+c_OFS -: 3];
  assign REG_Src2 = IR[2+c_OFS -: 3];
  assign REG_Src1 = Src1_Sel ? IR[6+c_OFS -: 3] : IR[11+c_OFS -: 3];

  // Flags are {V,N,C,Z}
  always_comb begin
    case (w_cond)
      2'b00:   w_taken = ALU_FlgsIn[0];
      2'b01:   w_taken = ~ALU_FlgsIn[0];
      2'b10:   w_taken = ALU_FlgsIn[2] ^ ALU_FlgsIn[3];
      default: w_taken = ALU_FlgsIn[1];
    endcase
  end

`ifdef SEQ_INTERRUPT_EN
  logic r_in_service, w_isr_set, w_isr_clr;

  always_ff @(posedge Clk) begin
    if (!Reset)         r_in_service <= 1'b0;
    else if (w_isr_set) r_in_service <= 1'b1;
    else if (w_isr_clr) r_in_service <= 1'b0;
  end
`endif

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= S_RESET;
      r_wait  <= 8'd0;
    end else begin
      r_state <= w_next;
      if (w_wait_clr)      r_wait <= 8'd0;
      else if (w_wait_inc) r_wait <= r_wait + 8'd1;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_wait_clr = 1'b0;
    w_wait_inc = 1'b0;
    STK_Ld = 1'b1; IR_Ld  = 1'b1; PC_Ld  = 1'b1; PC_Rst  = 1'b1; PC_Inc = 1'b1;
    MEM_Wr = 1'b1; MEM_En = 1'b1; REG_WE = 1'b1; FLG_Ld  = 1'b1; FLG_Rst = 1'b1;
    BRA_Src = 1'b0; Src1_Sel = 1'b0;
    PC_Src = 2'b00; ADDR_Src = 2'b00; DATA_Src = 2'b00;
    ALU_Op = 4'h0; Halt = 1'b0; Fault = 1'b0;
`ifdef SEQ_INTERRUPT_EN
    Int_Ack = 1'b0; w_isr_set = 1'b0; w_isr_clr = 1'b0;
`endif
    case (r_state)
      S_RESET: begin
        PC_Rst = 1'b0; FLG_Rst = 1'b0;
        w_next = S_FETCH_ADDR;
      end
      S_FETCH_ADDR: begin
        w_wait_clr = 1'b1;
        MEM_En     = 1'b0;
        w_next     = S_FETCH_WAIT;
`ifdef SEQ_INTERRUPT_EN
        if (Int_Req && !r_in_service) begin
          MEM_En = 1'b1;
          w_next = S_INT;
        end
`endif
      end
      S_FETCH_WAIT: begin
        MEM_En = 1'b0;
        if (MEM_Rdy) begin
          IR_Ld = 1'b0; PC_Inc = 1'b0;
          w_next = S_DECODE;
        end else begin
          w_wait_inc = 1'b1;
          if (w_wait_hit) w_next = S_FAULT;
        end
      end
      S_DECODE: begin
        w_wait_clr = 1'b1;
        w_next     = S_FETCH_ADDR;
        case (w_opcode)
          c_OP_LDI: REG_WE = 1'b0;
          c_OP_LD: begin
            MEM_En = 1'b0; ADDR_Src = 2'b10; w_next = S_EXECUTE;
          end
          c_OP_ST, c_OP_STX: begin
            MEM_En = 1'b0; MEM_Wr = 1'b0; ADDR_Src = 2'b10;
            Src1_Sel = (w_opcode == c_OP_STX); w_next = S_EXECUTE;
          end
          c_OP_JPL: begin
            Src1_Sel = 1'b1; PC_Src = 2'b10; PC_Ld = 1'b0;
            STK_Ld = IR[11+c_OFS];
          end
          c_OP_RET: begin
            PC_Src = 2'b01; PC_Ld = 1'b0;
`ifdef SEQ_INTERRUPT_EN
            w_isr_clr = 1'b1;
`endif
          end
          c_OP_BRD, c_OP_BRX: begin
            if (w_taken) begin
              PC_Ld = 1'b0;
              if (w_opcode == c_OP_BRD) BRA_Src  = 1'b1;
              else                      Src1_Sel = 1'b1;
            end
          end
          c_OP_ALU: begin
            ALU_Op = w_alu_fn; w_next = S_EXECUTE;
          end
          c_OP_HLT: w_next = S_HALT;
          default:  w_next = S_FETCH_ADDR;
        endcase
      end
      S_EXECUTE: begin
        w_next = S_FETCH_ADDR;
        case (w_opcode)
          c_OP_LD, c_OP_ST, c_OP_STX: begin
            MEM_En = 1'b0; ADDR_Src = 2'b10;
            if (w_opcode != c_OP_LD) begin
              MEM_Wr = 1'b0; Src1_Sel = (w_opcode == c_OP_STX);
            end
            if (MEM_Rdy) begin
              if (w_opcode == c_OP_LD) begin
                REG_WE = 1'b0; DATA_Src = 2'b01;
              end
            end else begin
              w_wait_inc = 1'b1;
              w_next     = w_wait_hit ? S_FAULT : S_EXECUTE;
            end
          end
          c_OP_ALU: begin
            ALU_Op = w_alu_fn; REG_WE = 1'b0; DATA_Src = 2'b10; FLG_Ld = 1'b0;
          end
          default: w_next = S_FETCH_ADDR;
        endcase
      end
      S_HALT: begin
        Halt = 1'b1;
`ifdef SEQ_INTERRUPT_EN
        if (Int_Req) w_next = S_INT;
`endif
      end
      S_FAULT: begin
        Halt = 1'b1; Fault = 1'b1;
      end
`ifdef SEQ_INTERRUPT_EN
      S_INT: begin
        STK_Ld = 1'b0; PC_Src = 2'b11; PC_Ld = 1'b0; Int_Ack = 1'b1;
        w_isr_set = 1'b1; w_next = S_FETCH_ADDR;
      end
`endif
      default: w_next = S_RESET;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_sequence_control_p.sv
`default_nettype none
// Directed bench for sequence_control_p: per-instruction cycle expectations are
// built from the instruction timing rules and checked every cycle.
module tb_sequence_control_p;

  logic        Clk, Reset, MEM_Rdy;
  logic [15:0] IR;
  logic [3:0]  ALU_FlgsIn;
  logic STK_Ld, IR_Ld, PC_Ld, PC_Rst, PC_Inc, MEM_Wr, MEM_En, REG_WE, FLG_Ld, FLG_Rst;
  logic BRA_Src, Src1_Sel, Halt, Fault;
  logic [1:0] PC_Src, ADDR_Src, DATA_Src;
  logic [2:0] REG_Dest, REG_Src1, REG_Src2;
  logic [3:0] ALU_Op;
`ifdef SEQ_INTERRUPT_EN
  logic Int_Req, Int_Ack;
  initial Int_Req = 1'b0;
`endif

  sequence_control_p #(.DataWidth(16), .WaitMax(7)) dut (
    .Clk(Clk), .Reset(Reset), .IR(IR), .ALU_FlgsIn(ALU_FlgsIn), .MEM_Rdy(MEM_Rdy),
`ifdef SEQ_INTERRUPT_EN
    .Int_Req(Int_Req), .Int_Ack(Int_Ack),
`endif
    .STK_Ld(STK_Ld), .IR_Ld(IR_Ld), .PC_Ld(PC_Ld), .PC_Rst(PC_Rst), .PC_Inc(PC_Inc),
    .MEM_Wr(MEM_Wr), .MEM_En(MEM_En), .REG_WE(REG_WE), .FLG_Ld(FLG_Ld), .FLG_Rst(FLG_Rst),
    .BRA_Src(BRA_Src), .Src1_Sel(Src1_Sel), .PC_Src(PC_Src), .ADDR_Src(ADDR_Src),
    .DATA_Src(DATA_Src), .REG_Dest(REG_Dest), .REG_Src1(REG_Src1), .REG_Src2(REG_Src2),
    .ALU_Op(ALU_Op), .Halt(Halt), .Fault(Fault)
  );

  typedef struct packed {
    logic       chk;
    logic       stk_ld, ir_ld, pc_ld, pc_rst, pc_inc, mem_wr, mem_en, reg_we, flg_ld, flg_rst;
    logic       bra_src, src1_sel;
    logic [1:0] pc_src, addr_src, data_src;
    logic [2:0] reg_dest, reg_src1, reg_src2;
    logic [3:0] alu_op;
    logic       halt, fault;
  } exp_t;

  exp_t        exp_q[$];
  string       nm_q[$];
  int          total = 0, bad = 0;
  int          icyc = 0, lit_cyc = 0;
  logic [14:0] lit_want;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  always @(negedge Clk) begin
    exp_t w, g;
    string n;
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      n = nm_q.pop_front();
      g = {1'b1, STK_Ld, IR_Ld, PC_Ld, PC_Rst, PC_Inc, MEM_Wr, MEM_En, REG_WE, FLG_Ld,
           FLG_Rst, BRA_Src, Src1_Sel, PC_Src, ADDR_Src, DATA_Src, REG_Dest, REG_Src1,
           REG_Src2, ALU_Op, Halt, Fault};
      if (w.chk) begin
        total++;
        if (g !== w) begin
          bad++;
          $display("FAIL %s (IR=%h): got %h want %h", n, IR, g, w);
        end
      end
    end
  end

  // Quiet outputs; register addresses always follow the IR fields.
  function automatic exp_t base();
    exp_t e;
    e = '0;
    e.chk = 1'b1;
    {e.stk_ld, e.ir_ld, e.pc_ld, e.pc_rst, e.pc_inc} = 5'b11111;
    {e.mem_wr, e.mem_en, e.reg_we, e.flg_ld, e.flg_rst} = 5'b11111;
    e.reg_dest = IR[11:9];
    e.reg_src1 = IR[11:9];
    e.reg_src2 = IR[2:0];
    return e;
  endfunction

  function automatic logic br_taken(input logic [1:0] cond, input logic [3:0] f);
    case (cond)
      2'b00:   return f[0];
      2'b01:   return !f[0];
      2'b10:   return f[2] != f[3];
      default: return f[1];
    endcase
  endfunction

  task automatic lit_check(input logic [14:0] want);
    logic [14:0] got;
    got = {PC_Ld, BRA_Src, REG_WE, DATA_Src, FLG_Ld, ALU_Op, REG_Dest, Halt, Fault};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL literal cycle %0d IR=%h: got %b want %b", lit_cyc, IR, got, want);
    end
  endtask

  task automatic step(input logic rdy, input exp_t e, input string nm);
    MEM_Rdy = rdy;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    icyc++;
    if (icyc == lit_cyc) begin
      #1;
      lit_check(lit_want);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset(input exp_t during);
    exp_t e;
    Reset = 1'b0;
    step(1'b0, during, "reset_low");
    Reset = 1'b1;
    e = base();
    e.pc_rst  = 1'b0;
    e.flg_rst = 1'b0;
    step(1'b0, e, "reset_state");
  endtask

  task automatic run_instr(input logic [15:0] ir, input logic [3:0] flg, input int fw, input int xw);
    exp_t e;
    logic [3:0] op;
    IR = ir; ALU_FlgsIn = flg; op = ir[15:12]; icyc = 0;
    e = base(); e.mem_en = 1'b0;
    step(1'b0, e, "fetch_addr");
    for (int i = 0; i < fw; i++) step(1'b0, e, "fetch_wait");
    e.ir_ld = 1'b0; e.pc_inc = 1'b0;
    step(1'b1, e, "fetch_done");
    e = base();
    case (op)
      4'd1: begin e.reg_we = 1'b0; step(1'b0, e, "ldi"); end
      4'd2: begin
        e.mem_en = 1'b0; e.addr_src = 2'b10;
        step(1'b0, e, "ld_decode");
        for (int i = 0; i < xw; i++) step(1'b0, e, "ld_wait");
        e.reg_we = 1'b0; e.data_src = 2'b01;
        step(1'b1, e, "ld_done");
      end
      4'd3, 4'd4: begin
        e.mem_en = 1'b0; e.mem_wr = 1'b0; e.addr_src = 2'b10;
        if (op == 4'd4) begin e.src1_sel = 1'b1; e.reg_src1 = ir[6:4]; end
        step(1'b0, e, "st_decode");
        for (int i = 0; i < xw; i++) step(1'b0, e, "st_wait");
        step(1'b1, e, "st_done");
      end
      4'd5: begin
        e.src1_sel = 1'b1; e.reg_src1 = ir[6:4]; e.pc_src = 2'b10;
        e.pc_ld = 1'b0; e.stk_ld = ir[11];
        step(1'b0, e, "jpl");
      end
      4'd6: begin e.pc_src = 2'b01; e.pc_ld = 1'b0; step(1'b0, e, "ret"); end
      4'd7, 4'd8: begin
        if (br_taken(ir[11:10], flg)) begin
          e.pc_ld = 1'b0;
          if (op == 4'd7) e.bra_src = 1'b1;
          else begin e.src1_sel = 1'b1; e.reg_src1 = ir[6:4]; end
        end
        step(1'b0, e, "branch");
      end
      4'd9: begin
        e.alu_op = ir[3:0];
        step(1'b0, e, "alu_decode");
        e.reg_we = 1'b0; e.data_src = 2'b10; e.flg_ld = 1'b0;
        step(1'b0, e, "alu_exec");
      end
      default: step(1'b0, e, (op == 4'd15) ? "hlt_decode" : "nop");
    endcase
  endtask

  initial begin
    exp_t e;
    Reset = 1'b0; IR = 16'h0000; ALU_FlgsIn = 4'h0; MEM_Rdy = 1'b0;
    @(posedge Clk);
    #1;
    e = '0;
    do_reset(e);

    run_instr(16'h0000, 4'h0, 0, 0);
    run_instr(16'h1234, 4'h0, 0, 0);
    lit_cyc = 4; lit_want = 15'b1_0_0_01_1_0000_001_0_0;
    run_instr(16'h2345, 4'h0, 0, 0);
    lit_cyc = 7;
    run_instr(16'h2345, 4'h0, 0, 3);
    lit_cyc = 0;
    run_instr(16'h3456, 4'h0, 1, 2);
    run_instr(16'h4456, 4'h0, 0, 2);
    run_instr(16'h5870, 4'h0, 0, 0);
    run_instr(16'h5070, 4'h0, 0, 0);
    run_instr(16'h6000, 4'h0, 0, 0);
    lit_cyc = 3; lit_want = 15'b0_1_1_00_1_0000_010_0_0;
    run_instr(16'h7400, 4'b0000, 0, 0);
    lit_want = 15'b1_0_1_00_1_0000_010_0_0;
    run_instr(16'h7400, 4'b0001, 0, 0);
    lit_cyc = 0;
    run_instr(16'h7000, 4'b0001, 0, 0);
    run_instr(16'h7800, 4'b0100, 0, 0);
    run_instr(16'h7800, 4'b1100, 0, 0);
    run_instr(16'h7C00, 4'b0010, 0, 0);
    run_instr(16'h7C00, 4'b1101, 0, 0);
    run_instr(16'h8412, 4'b0000, 0, 0);
    run_instr(16'h8012, 4'b0000, 0, 0);
    lit_cyc = 4; lit_want = 15'b1_0_0_10_0_0010_101_0_0;
    run_instr(16'h9A12, 4'h0, 0, 0);
    lit_cyc = 0;
    run_instr(16'hB123, 4'h0, 0, 0);
    // Ready on the last tolerated wait cycle still completes; counter restarts per access.
    run_instr(16'h0000, 4'h0, 6, 0);
    run_instr(16'h2345, 4'h0, 6, 6);

    // Reset in the middle of a load drops the memory strobes.
    IR = 16'h2345; icyc = 0;
    e = base(); e.mem_en = 1'b0; step(1'b0, e, "fetch_addr");
    e.ir_ld = 1'b0; e.pc_inc = 1'b0; step(1'b1, e, "fetch_done");
    e = base(); e.mem_en = 1'b0; e.addr_src = 2'b10;
    step(1'b0, e, "ld_decode");
    step(1'b0, e, "ld_wait");
    do_reset(e);

    lit_cyc = 23; lit_want = 15'b1_0_1_00_1_0000_000_1_0;
    run_instr(16'hF000, 4'h0, 0, 0);
    e = base(); e.halt = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b0, e, "halt");
    lit_cyc = 0;
    do_reset(e);

    // Memory never ready: seven wait cycles, then fault until reset.
    IR = 16'h0000; icyc = 0;
    lit_cyc = 9; lit_want = 15'b1_0_1_00_1_0000_000_1_1;
    e = base(); e.mem_en = 1'b0; step(1'b0, e, "fetch_addr");
    for (int i = 0; i < 7; i++) step(1'b0, e, "fetch_wait");
    e = base(); e.halt = 1'b1; e.fault = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, e, "fault");
    lit_cyc = 0;
    do_reset(e);
    run_instr(16'h1234, 4'h0, 0, 0);

    @(negedge Clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
